// File: rtl/alu_src_b_reg.sv
// Registered ALU operand-B selector: eight-way source set with immediate
// extension, shift and LUI forms, load/flush control, valid and sticky error.
module alu_src_b_reg #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16,
  parameter int CONST_INC = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 flush,
  input  logic [2:0]           selector,
  input  logic [WIDTH-1:0]     data_0,
  input  logic [WIDTH-1:0]     data_1,
  input  logic [IMM_WIDTH-1:0] imm,
  output logic [WIDTH-1:0]     data_out,
  output logic                 out_valid,
  output logic                 sel_err
);

  localparam int                PAD_W   = WIDTH - IMM_WIDTH;
  localparam logic [WIDTH-1:0]  CONST_W = WIDTH'(CONST_INC);
  localparam logic [2:0]        SEL_ILL = 3'd7;

  function automatic logic signed [WIDTH-1:0] sign_ext(input logic [IMM_WIDTH-1:0] v);
    return {{PAD_W{v[IMM_WIDTH-1]}}, v};
  endfunction

  function automatic logic [WIDTH-1:0] zero_ext(input logic [IMM_WIDTH-1:0] v);
    return {{PAD_W{1'b0}}, v};
  endfunction

  function automatic logic [WIDTH-1:0] lui_form(input logic [IMM_WIDTH-1:0] v);
    return {v, {PAD_W{1'b0}}};
  endfunction

  logic signed [WIDTH-1:0] sext;
  logic [WIDTH-1:0]        sel_val;
  logic                    sel_ill;

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  assign sext    = sign_ext(imm);
  assign sel_ill = (selector == SEL_ILL);

  always_comb begin
    sel_val = '0;
    case (selector)
      3'd0:    sel_val = data_0;
      3'd1:    sel_val = CONST_W;
      3'd2:    sel_val = data_1;
      3'd3:    sel_val = sext;
      // Top two bits of the extended immediate fall off; no overflow reported.
      3'd4:    sel_val = sext <<< 2;
      3'd5:    sel_val = zero_ext(imm);
      3'd6:    sel_val = lui_form(imm);
      default: sel_val = '0;
    endcase
  end

  // Flush outranks load; an illegal select only raises the error and holds data.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (flush) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (load) begin
      if (sel_ill) begin
        err_d = 1'b1;
      end else begin
        data_d  = sel_val;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_alu_src_b_reg.sv
// Self-checking bench for alu_src_b_reg: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_alu_src_b_reg;

  localparam int W  = 32;
  localparam int IW = 16;
  localparam int CI = 4;

  logic          clk;
  logic          reset;
  logic          load;
  logic          flush;
  logic [2:0]    selector;
  logic [W-1:0]  data_0;
  logic [W-1:0]  data_1;
  logic [IW-1:0] imm;
  logic [W-1:0]  data_out;
  logic          out_valid;
  logic          sel_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_err;

  alu_src_b_reg #(.WIDTH(W), .IMM_WIDTH(IW), .CONST_INC(CI)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .flush     (flush),
    .selector  (selector),
    .data_0    (data_0),
    .data_1    (data_1),
    .imm       (imm),
    .data_out  (data_out),
    .out_valid (out_valid),
    .sel_err   (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Operand value from the source rules, using plain integer arithmetic.
  function automatic logic [W-1:0] ref_val(input int sel, input logic [W-1:0] d0,
                                           input logic [W-1:0] d1, input logic [IW-1:0] im);
    longint z;
    longint s;
    z = longint'(im);
    s = (z >= (longint'(1) << (IW - 1))) ? z - (longint'(1) << IW) : z;
    case (sel)
      0:       return d0;
      1:       return W'(CI);
      2:       return d1;
      3:       return W'(s);
      4:       return W'(s * 4);
      5:       return W'(z);
      6:       return W'(z * (longint'(1) << (W - IW)));
      default: return '0;
    endcase
  endfunction

  task automatic model_clear();
    m_data  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge();
    if (flush) begin
      m_data  = '0;
      m_valid = 1'b0;
    end else if (load) begin
      if (selector == 3'd7) m_err = 1'b1;
      else begin
        m_data  = ref_val(int'(selector), data_0, data_1, imm);
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string t);
    check_eq({t, ".data"}, data_out, m_data);
    check_eq({t, ".vld"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, m_valid});
    check_eq({t, ".err"}, {{(W-1){1'b0}}, sel_err}, {{(W-1){1'b0}}, m_err});
  endtask

  task automatic tick(input string t);
    @(posedge clk);
    if (reset) model_edge();
    #1;
    check_all(t);
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b0;
    model_clear();
    #1 check_all("rst_pulse");
    reset = 1'b1;
  endtask

  initial begin
    logic [W-1:0] dir_exp [5];
    int           dir_sel [5];
    logic [W-1:0] hold_data;

    dir_sel = '{1, 3, 4, 5, 6};
    dir_exp = '{32'h0000_0004, 32'hFFFF_8001, 32'hFFFE_0004, 32'h0000_8001, 32'h8001_0000};
    model_clear();

    // Reset held while a load is requested
    reset = 1'b0; load = 1'b1; flush = 1'b0; selector = 3'd0;
    data_0 = 32'hDEAD_BEEF; data_1 = '0; imm = '0;
    tick("rst_hold0");
    tick("rst_hold1");
    reset = 1'b1;
    tick("rst_rel_load");
    check_eq("rst_rel_const", data_out, 32'hDEAD_BEEF);

    // Immediate forms with imm = 0x8001
    imm = 16'h8001;
    for (int i = 0; i < 5; i++) begin
      selector = 3'(dir_sel[i]);
      tick($sformatf("imm_sel%0d", dir_sel[i]));
      check_eq($sformatf("imm_const%0d", dir_sel[i]), data_out, dir_exp[i]);
    end

    // Illegal select holds data and sets the sticky flag
    selector = 3'd0; data_0 = 32'h1234_5678;
    tick("ill_pre");
    selector = 3'd7;
    tick("ill_sel");
    check_eq("ill_hold_const", data_out, 32'h1234_5678);
    check_eq("ill_err_const", {{(W-1){1'b0}}, sel_err}, 32'd1);
    selector = 3'd2; data_1 = 32'hA5A5_A5A5;
    tick("ill_after");
    check_eq("ill_after_const", data_out, 32'hA5A5_A5A5);

    // Flush beats load; sel_err survives flush
    flush = 1'b1; load = 1'b1; selector = 3'd0; data_0 = 32'h1111_1111;
    tick("flush_load");
    flush = 1'b0; load = 1'b0;
    tick("flush_hold");
    check_eq("flush_err_kept", {{(W-1){1'b0}}, sel_err}, 32'd1);

    // Hold with load low while inputs churn
    pulse_reset();
    load = 1'b1; selector = 3'd0; data_0 = 32'hCAFE_F00D;
    tick("hold_pre");
    hold_data = data_out;
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      selector = 3'(i % 8);
      data_0 = $urandom; data_1 = $urandom; imm = IW'($urandom);
      tick("hold");
      check_eq("hold_const", data_out, hold_data);
      check_eq("hold_noerr", {{(W-1){1'b0}}, sel_err}, 32'd0);
    end

    // Asynchronous reset between edges
    load = 1'b1; selector = 3'd7;
    tick("mid_ill");
    selector = 3'd0; data_0 = 32'h0000_ABCD;
    tick("mid_load");
    #2 reset = 1'b0;
    model_clear();
    #1 check_all("mid_rst");
    reset = 1'b1; load = 1'b0;
    tick("mid_rel");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      load     = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      selector = 3'($urandom_range(0, 7));
      data_0   = $urandom;
      data_1   = $urandom;
      imm      = IW'($urandom);
      tick("rnd");
      selector = 3'($urandom_range(0, 7));
      data_0   = $urandom;
      imm      = IW'($urandom);
      #1 check_all("rnd_nocomb");
      if ($urandom_range(0, 49) == 0) pulse_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
